// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS datapath.
// Holds decode-stage operands/controls for one cycle and presents forwarded
// ALU operands, the 3-bit ALU control code and the destination register to EX.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic [WIDTH-1:0]   rd1_d,
  input  logic [WIDTH-1:0]   rd2_d,
  input  logic [WIDTH-1:0]   signimm_d,
  input  logic [REGBITS-1:0] rs_d,
  input  logic [REGBITS-1:0] rt_d,
  input  logic [REGBITS-1:0] rd_d,
  input  logic               regwrite_d,
  input  logic               memtoreg_d,
  input  logic               memwrite_d,
  input  logic               alusrc_d,
  input  logic               regdst_d,
  input  logic [1:0]         aluop_d,
  input  logic [5:0]         funct_d,
  input  logic               valid_d,
  input  logic               regwrite_m,
  input  logic [REGBITS-1:0] writereg_m,
  input  logic [WIDTH-1:0]   aluout_m,
  input  logic               regwrite_w,
  input  logic [REGBITS-1:0] writereg_w,
  input  logic [WIDTH-1:0]   result_w,
  output logic [WIDTH-1:0]   srca_e,
  output logic [WIDTH-1:0]   srcb_e,
  output logic [2:0]         alucontrol_e,
  output logic [WIDTH-1:0]   writedata_e,
  output logic [REGBITS-1:0] writereg_e,
  output logic               regwrite_e,
  output logic               memtoreg_e,
  output logic               memwrite_e,
  output logic               valid_e,
  output logic               illegal_e
);

  logic [WIDTH-1:0]   rd1_reg, rd2_reg, signimm_reg;
  logic [REGBITS-1:0] rs_reg, rt_reg, rd_reg;
  logic               regwrite_reg, memtoreg_reg, memwrite_reg;
  logic               alusrc_reg, regdst_reg, valid_reg;
  logic [1:0]         aluop_reg;
  logic [5:0]         funct_reg;

  // Pipeline register: reset/flush insert an all-zero bubble, stall holds, else load.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      signimm_reg  <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      memwrite_reg <= 1'b0;
      alusrc_reg   <= 1'b0;
      regdst_reg   <= 1'b0;
      aluop_reg    <= '0;
      funct_reg    <= '0;
      valid_reg    <= 1'b0;
    end else if (!stall_e) begin
      rd1_reg      <= rd1_d;
      rd2_reg      <= rd2_d;
      signimm_reg  <= signimm_d;
      rs_reg       <= rs_d;
      rt_reg       <= rt_d;
      rd_reg       <= rd_d;
      regwrite_reg <= regwrite_d;
      memtoreg_reg <= memtoreg_d;
      memwrite_reg <= memwrite_d;
      alusrc_reg   <= alusrc_d;
      regdst_reg   <= regdst_d;
      aluop_reg    <= aluop_d;
      funct_reg    <= funct_d;
      valid_reg    <= valid_d;
    end
  end

  // Operand 0 is A (rs), operand 1 is B (rt); both share the same forwarding rule.
  logic [1:0][REGBITS-1:0] op_reg;
  logic [1:0][WIDTH-1:0]   op_data;
  logic [1:0][WIDTH-1:0]   op_fwd;

  assign op_reg[0]  = rs_reg;
  assign op_reg[1]  = rt_reg;
  assign op_data[0] = rd1_reg;
  assign op_data[1] = rd2_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_m, hit_w;
      // $0 is hard-wired, so a pending write to it must never be forwarded.
      assign hit_m      = regwrite_m && (writereg_m != '0) && (writereg_m == op_reg[gi]);
      assign hit_w      = regwrite_w && (writereg_w != '0) && (writereg_w == op_reg[gi]);
      // EX/MEM holds the younger result, so it wins over MEM/WB.
      assign op_fwd[gi] = hit_m ? aluout_m : (hit_w ? result_w : op_data[gi]);
    end
  endgenerate

  assign srca_e      = op_fwd[0];
  assign writedata_e = op_fwd[1];
  assign srcb_e      = alusrc_reg ? signimm_reg : op_fwd[1];
  assign writereg_e  = regdst_reg ? rd_reg : rt_reg;
  assign regwrite_e  = regwrite_reg;
  assign memtoreg_e  = memtoreg_reg;
  assign memwrite_e  = memwrite_reg;
  assign valid_e     = valid_reg;

  // ALU decoder: aluop selects add/sub directly, R-type defers to funct.
  always_comb begin
    alucontrol_e = 3'b010;
    illegal_e    = 1'b0;
    case (aluop_reg)
      2'b00:   alucontrol_e = 3'b010;
      2'b01:   alucontrol_e = 3'b110;
      default: begin
        case (funct_reg)
          6'b100000: alucontrol_e = 3'b010;
          6'b100010: alucontrol_e = 3'b110;
          6'b100100: alucontrol_e = 3'b000;
          6'b100101: alucontrol_e = 3'b001;
          6'b101010: alucontrol_e = 3'b111;
          default: begin
            alucontrol_e = 3'b010;
            illegal_e    = valid_reg;
          end
        endcase
      end
    endcase
  end

endmodule
